// File: rtl/seg_stream_pkg.sv
// Shared constants for the seven-segment serial stream receiver.
// Segment bytes map a=bit0 .. g=bit6; bit7 must be zero for a valid code.
package seg_stream_pkg;

  localparam int NUM_DIGITS = 6;
  localparam logic [2:0] IDX_LAST = 3'(NUM_DIGITS - 1);

  localparam logic [7:0] SEG_0 = 8'h3F;
  localparam logic [7:0] SEG_1 = 8'h06;
  localparam logic [7:0] SEG_2 = 8'h5B;
  localparam logic [7:0] SEG_3 = 8'h4F;
  localparam logic [7:0] SEG_4 = 8'h66;
  localparam logic [7:0] SEG_5 = 8'h6D;
  localparam logic [7:0] SEG_6 = 8'h7D;
  localparam logic [7:0] SEG_7 = 8'h07;
  localparam logic [7:0] SEG_8 = 8'h7F;
  localparam logic [7:0] SEG_9 = 8'h6F;

  localparam logic [3:0] NIBBLE_INV = 4'hF;

endpackage

// File: rtl/seg_decoder.sv
// Combinational seven-segment byte to BCD nibble decoder.
// Unknown patterns (including any with bit7 set) give NIBBLE_INV and valid=0.
module seg_decoder
  import seg_stream_pkg::*;
(
  input  logic [7:0] i_seg,
  output logic [3:0] o_nibble,
  output logic       o_valid
);

  always_comb begin
    o_nibble = NIBBLE_INV;
    o_valid  = 1'b1;
    case (i_seg)
      SEG_0:   o_nibble = 4'd0;
      SEG_1:   o_nibble = 4'd1;
      SEG_2:   o_nibble = 4'd2;
      SEG_3:   o_nibble = 4'd3;
      SEG_4:   o_nibble = 4'd4;
      SEG_5:   o_nibble = 4'd5;
      SEG_6:   o_nibble = 4'd6;
      SEG_7:   o_nibble = 4'd7;
      SEG_8:   o_nibble = 4'd8;
      SEG_9:   o_nibble = 4'd9;
      default: o_valid  = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg_stream_rx.sv
// Receives a serial seven-segment stream (sclk/latch/bit) and rebuilds BCD time.
// Define SEG_STREAM_RX_SYNC_EN to insert a 2-flop synchronizer on each serial input.
module seg_stream_rx
  import seg_stream_pkg::*;
#(
  parameter int IDLE_CYCLES = 1024
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_sclk,
  input  logic       i_latch,
  input  logic       i_bit,
  input  logic       i_err_clr,
  output logic [7:0] o_seconds,
  output logic [7:0] o_minutes,
  output logic [7:0] o_hours,
  output logic       o_frame,
  output logic       o_err
);

  localparam int IDLE_W = $clog2(IDLE_CYCLES + 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(IDLE_CYCLES);

  // Input pipeline: bit0 = sclk, bit1 = latch, bit2 = data.
  logic [2:0] samp_q;
  logic [1:0] hist_q;

`ifdef SEG_STREAM_RX_SYNC_EN
  logic [2:0] meta_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      meta_q <= 3'b000;
      samp_q <= 3'b000;
    end else begin
      meta_q <= {i_bit, i_latch, i_sclk};
      samp_q <= meta_q;
    end
  end
`else
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      samp_q <= 3'b000;
    end else begin
      samp_q <= {i_bit, i_latch, i_sclk};
    end
  end
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hist_q <= 2'b00;
    end else begin
      hist_q <= samp_q[1:0];
    end
  end

  logic sclk_rise;
  logic latch_rise;
  logic any_edge;

  assign sclk_rise  = samp_q[0] & ~hist_q[0];
  assign latch_rise = samp_q[1] & ~hist_q[1];
  assign any_edge   = sclk_rise | latch_rise;

  logic [7:0]        shift_q;
  logic [3:0]        bit_cnt_q;
  logic [2:0]        idx_q;
  logic [3:0]        staging_q [NUM_DIGITS];
  logic [IDLE_W-1:0] idle_q;
  logic              frame_pend_q;
  logic [7:0]        sec_q;
  logic [7:0]        min_q;
  logic [7:0]        hr_q;
  logic              frame_q;
  logic              err_q;

  logic [3:0] dec_nibble;
  logic       dec_valid;

  seg_decoder u_dec (
    .i_seg    (shift_q),
    .o_nibble (dec_nibble),
    .o_valid  (dec_valid)
  );

  // The latch always judges the byte as it stood before any coincident shift.
  logic       byte_ok;
  logic [3:0] digit_d;
  logic       err_set;

  assign byte_ok = (bit_cnt_q == 4'd8) && dec_valid;
  assign digit_d = byte_ok ? dec_nibble : NIBBLE_INV;
  assign err_set = latch_rise && !byte_ok;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      shift_q      <= 8'h00;
      bit_cnt_q    <= 4'd0;
      idx_q        <= 3'd0;
      idle_q       <= '0;
      frame_pend_q <= 1'b0;
      sec_q        <= 8'h00;
      min_q        <= 8'h00;
      hr_q         <= 8'h00;
      frame_q      <= 1'b0;
      err_q        <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) staging_q[i] <= 4'h0;
    end else begin
      frame_pend_q <= 1'b0;
      frame_q      <= 1'b0;

      // Outputs load one edge after the last digit lands in staging.
      if (frame_pend_q) begin
        sec_q   <= {staging_q[1], staging_q[0]};
        min_q   <= {staging_q[3], staging_q[2]};
        hr_q    <= {staging_q[5], staging_q[4]};
        frame_q <= 1'b1;
      end

      if (any_edge) begin
        idle_q <= '0;
      end else if (idle_q != IDLE_MAX) begin
        idle_q <= idle_q + IDLE_W'(1);
      end

      if (sclk_rise) begin
        shift_q <= {shift_q[6:0], samp_q[2]};
      end

      if (latch_rise) begin
        staging_q[idx_q] <= digit_d;
        bit_cnt_q        <= sclk_rise ? 4'd1 : 4'd0;
        if (idx_q == IDX_LAST) begin
          idx_q        <= 3'd0;
          frame_pend_q <= 1'b1;
        end else begin
          idx_q <= idx_q + 3'd1;
        end
      end else if (sclk_rise) begin
        if (bit_cnt_q != 4'd15) bit_cnt_q <= bit_cnt_q + 4'd1;
      end else if (idle_q == IDLE_MAX) begin
        idx_q     <= 3'd0;
        bit_cnt_q <= 4'd0;
      end

      if (err_set) begin
        err_q <= 1'b1;
      end else if (i_err_clr) begin
        err_q <= 1'b0;
      end
    end
  end

  assign o_seconds = sec_q;
  assign o_minutes = min_q;
  assign o_hours   = hr_q;
  assign o_frame   = frame_q;
  assign o_err     = err_q;

endmodule

// File: tb/tb_seg_stream_rx.sv
// Directed bench for seg_stream_rx: frame decode, errors, idle realign,
// coincident sclk/latch and mid-frame reset.
module tb_seg_stream_rx;

  localparam int IDLE = 64;

  logic       clk;
  logic       rst_n;
  logic       sclk;
  logic       latch;
  logic       sbit;
  logic       err_clr;
  logic [7:0] seconds;
  logic [7:0] minutes;
  logic [7:0] hours;
  logic       frame;
  logic       err;

  int total_cnt;
  int pass_cnt;
  int frame_cnt;
  int wide_cnt;
  logic frame_prev;

  seg_stream_rx #(.IDLE_CYCLES(IDLE)) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_sclk    (sclk),
    .i_latch   (latch),
    .i_bit     (sbit),
    .i_err_clr (err_clr),
    .o_seconds (seconds),
    .o_minutes (minutes),
    .o_hours   (hours),
    .o_frame   (frame),
    .o_err     (err)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame pulse monitor, sampled mid-cycle
  initial begin
    frame_cnt  = 0;
    wide_cnt   = 0;
    frame_prev = 1'b0;
  end

  always @(negedge clk) begin
    if (frame === 1'b1) frame_cnt++;
    if (frame === 1'b1 && frame_prev === 1'b1) wide_cnt++;
    frame_prev = frame;
  end

  // Driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    sbit = b;
    tick(1);
    sclk = 1'b1;
    tick(1);
    sclk = 1'b0;
    tick(1);
  endtask

  task automatic send_bits(input logic [7:0] b, input int nbits);
    for (int i = 7; i > 7 - nbits; i--) send_bit(b[i]);
  endtask

  task automatic pulse_latch();
    latch = 1'b1;
    tick(1);
    latch = 1'b0;
    tick(1);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_bits(b, 8);
    pulse_latch();
  endtask

  task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                            input logic [7:0] b3, input logic [7:0] b4, input logic [7:0] b5);
    send_byte(b0);
    send_byte(b1);
    send_byte(b2);
    send_byte(b3);
    send_byte(b4);
    send_byte(b5);
    tick(4);
  endtask

  // Scoreboard check
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic check_time(input string tag, input logic [7:0] s, input logic [7:0] m,
                            input logic [7:0] h);
    check({tag, "_sec"}, 32'(seconds), 32'(s));
    check({tag, "_min"}, 32'(minutes), 32'(m));
    check({tag, "_hr"}, 32'(hours), 32'(h));
  endtask

  initial begin
    total_cnt = 0;
    pass_cnt  = 0;
    rst_n     = 1'b0;
    sclk      = 1'b0;
    latch     = 1'b0;
    sbit      = 1'b0;
    err_clr   = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(2);

    // Reset state
    check_time("reset", 8'h00, 8'h00, 8'h00);
    check("reset_frame", 32'(frame), 32'd0);
    check("reset_err", 32'(err), 32'd0);

    // Basic frame: 20:45:21 reversed digit order on the wire
    send_frame(8'h3F, 8'h5B, 8'h6D, 8'h66, 8'h06, 8'h5B);
    check_time("f1", 8'h20, 8'h45, 8'h21);
    check("f1_err", 32'(err), 32'd0);
    check("f1_frames", 32'(frame_cnt), 32'd1);

    // Short (7-bit) byte in minute-units slot
    send_byte(8'h3F);
    send_byte(8'h5B);
    send_bits(8'h6D, 7);
    pulse_latch();
    send_byte(8'h66);
    send_byte(8'h06);
    send_byte(8'h5B);
    tick(4);
    check_time("short", 8'h20, 8'h4F, 8'h21);
    check("short_err", 32'(err), 32'd1);
    check("short_frames", 32'(frame_cnt), 32'd2);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    check("short_errclr", 32'(err), 32'd0);

    // Invalid segment code 0x49 in second-units slot
    send_byte(8'h49);
    tick(2);
    check("inv_err_set", 32'(err), 32'd1);
    check("inv_hold_sec", 32'(seconds), 32'h20);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    check("inv_errclr", 32'(err), 32'd0);
    send_byte(8'h5B);
    send_byte(8'h6D);
    send_byte(8'h66);
    send_byte(8'h06);
    send_byte(8'h5B);
    tick(4);
    check_time("inv", 8'h2F, 8'h45, 8'h21);
    check("inv_frames", 32'(frame_cnt), 32'd3);

    // Partial frame, idle realign, then full frame 59:38:17
    send_byte(8'h7F);
    send_byte(8'h7F);
    send_byte(8'h7F);
    tick(4);
    check_time("partial_hold", 8'h2F, 8'h45, 8'h21);
    tick(IDLE + 5);
    send_frame(8'h6F, 8'h6D, 8'h7F, 8'h4F, 8'h07, 8'h06);
    check_time("idle", 8'h59, 8'h38, 8'h17);
    check("idle_frames", 32'(frame_cnt), 32'd4);
    check("idle_err", 32'(err), 32'd0);

    // Coincident sclk and latch: 0x06 stored, 0x4F starts at bit_cnt 1
    send_bits(8'h06, 8);
    sbit = 1'b0;
    tick(1);
    sclk  = 1'b1;
    latch = 1'b1;
    tick(1);
    sclk  = 1'b0;
    latch = 1'b0;
    tick(1);
    send_bits(8'h4F << 1, 7);
    pulse_latch();
    send_byte(8'h7F);
    send_byte(8'h6D);
    send_byte(8'h5B);
    send_byte(8'h06);
    tick(4);
    check_time("coinc", 8'h31, 8'h58, 8'h12);
    check("coinc_err", 32'(err), 32'd0);
    check("coinc_frames", 32'(frame_cnt), 32'd5);

    // Reset mid-byte after an error, then a fresh frame 38:49:16
    send_byte(8'h3F);
    send_byte(8'h49);
    send_bits(8'h5B, 4);
    tick(2);
    check("pre_rst_err", 32'(err), 32'd1);
    rst_n = 1'b0;
    tick(3);
    check_time("rst", 8'h00, 8'h00, 8'h00);
    check("rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;
    tick(2);
    check("rst_frames", 32'(frame_cnt), 32'd5);
    send_frame(8'h7F, 8'h4F, 8'h6F, 8'h66, 8'h7D, 8'h06);
    check_time("post_rst", 8'h38, 8'h49, 8'h16);
    check("post_rst_err", 32'(err), 32'd0);
    check("post_rst_frames", 32'(frame_cnt), 32'd6);
    check("frame_width", 32'(wide_cnt), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
